// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: BCD digits with pause/resume and field adjust.
// Second and adjust dividers are internal; the only timing input is clk.
module stopwatch_counter #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int ADJ_TICKS     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = (ADJ_TICKS > 1) ? $clog2(ADJ_TICKS) : 1;
    localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);
    localparam logic [AW-1:0] ADJ_LAST = AW'(ADJ_TICKS - 1);

    typedef enum logic {
        RUN,
        PAUSED
    } state_t;

    state_t state, state_next;

    logic [SW-1:0] sec_div;
    logic [AW-1:0] adj_div;
    logic          sec_adv;
    logic          sec_tick;
    logic          adj_tick;

    logic [3:0] mt_n, mo_n, st_n, so_n;

    // Clamp a digit that has left its range back to zero.
    function automatic logic [3:0] clean(input logic [3:0] d,
                                         input logic [3:0] top);
        return (d > top) ? 4'd0 : d;
    endfunction

    // Two-digit BCD increment over 00..59, wrapping without carry out.
    function automatic logic [7:0] inc59(input logic [3:0] tens,
                                         input logic [3:0] ones);
        logic [3:0] t, o;
        t = tens;
        o = ones;
        if (o == 4'd9) begin
            o = 4'd0;
            t = (t == 4'd5) ? 4'd0 : t + 4'd1;
        end else begin
            o = o + 4'd1;
        end
        return {t, o};
    endfunction

    assign sec_adv  = (state == RUN) && !adj;
    assign sec_tick = sec_adv && (sec_div == SEC_LAST);
    assign adj_tick = adj && (adj_div == ADJ_LAST);
    assign running  = (state == RUN);

    // Run/pause state register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // A pause pulse toggles the state in any mode.
    always_comb begin
        state_next = state;
        if (pause) begin
            state_next = (state == RUN) ? PAUSED : RUN;
        end
    end

    // Second divider: counts only while running outside adjust mode.
    always_ff @(posedge clk) begin
        if (rst || !sec_adv || sec_tick) sec_div <= '0;
        else                             sec_div <= sec_div + 1'b1;
    end

    // Adjust divider: counts only while adj is held.
    always_ff @(posedge clk) begin
        if (rst || !adj || adj_tick) adj_div <= '0;
        else                         adj_div <= adj_div + 1'b1;
    end

    // Next digit values: ripple count on sec_tick, field bump on adj_tick.
    always_comb begin
        mt_n = clean(min_tens, 4'd5);
        mo_n = clean(min_ones, 4'd9);
        st_n = clean(sec_tens, 4'd5);
        so_n = clean(sec_ones, 4'd9);
        if (sec_tick) begin
            if (so_n == 4'd9) begin
                so_n = 4'd0;
                if (st_n == 4'd5) begin
                    st_n = 4'd0;
                    {mt_n, mo_n} = inc59(mt_n, mo_n);
                end else begin
                    st_n = st_n + 4'd1;
                end
            end else begin
                so_n = so_n + 4'd1;
            end
        end else if (adj_tick) begin
            if (sel) {st_n, so_n} = inc59(st_n, so_n);
            else     {mt_n, mo_n} = inc59(mt_n, mo_n);
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with short dividers.
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [15:0] bcd;

    int passed = 0;
    int total  = 0;

    stopwatch_counter #(
        .TICKS_PER_SEC(10),
        .ADJ_TICKS    (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pause   (pause),
        .adj     (adj),
        .sel     (sel),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running (running)
    );

    assign bcd = {min_tens, min_ones, sec_tens, sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        pause = 1'b0;
        adj   = 1'b0;
        sel   = 1'b0;
        cyc(2);
        check("reset_digits", 32'(bcd), 32'h0000);
        check("reset_running", 32'(running), 32'd1);

        // free-running count from reset
        rst = 1'b0;
        cyc(9);
        check("pre_first_sec", 32'(bcd), 32'h0000);
        cyc(1);
        check("first_sec", 32'(bcd), 32'h0001);
        check("first_running", 32'(running), 32'd1);
        cyc(580);
        check("at_0059", 32'(bcd), 32'h0059);
        cyc(10);
        check("roll_0100", 32'(bcd), 32'h0100);

        // adjust to 59:59, then wrap to 00:00
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        adj = 1'b1;
        sel = 1'b0;
        cyc(295);
        check("adj_min_59", 32'(bcd), 32'h5900);
        sel = 1'b1;
        cyc(295);
        check("adj_sec_59", 32'(bcd), 32'h5959);
        adj = 1'b0;
        cyc(9);
        check("hold_5959", 32'(bcd), 32'h5959);
        cyc(1);
        check("wrap_0000", 32'(bcd), 32'h0000);

        // pause at 00:03, resume
        cyc(30);
        check("at_0003", 32'(bcd), 32'h0003);
        pulse_pause();
        check("paused", 32'(running), 32'd0);
        cyc(100);
        check("frozen_0003", 32'(bcd), 32'h0003);
        pulse_pause();
        check("resumed", 32'(running), 32'd1);
        cyc(9);
        check("resume_hold", 32'(bcd), 32'h0003);
        cyc(1);
        check("resume_0004", 32'(bcd), 32'h0004);

        // pause on the same edge as a tick
        cyc(10);
        check("at_0005", 32'(bcd), 32'h0005);
        cyc(9);
        pulse_pause();
        check("tick_with_pause", 32'(bcd), 32'h0006);
        check("tick_pause_run", 32'(running), 32'd0);
        cyc(50);
        check("pause_hold_0006", 32'(bcd), 32'h0006);
        check("pause_hold_run", 32'(running), 32'd0);

        // adjust seconds at 02:59 without carry into minutes
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        adj = 1'b1;
        sel = 1'b0;
        cyc(10);
        sel = 1'b1;
        cyc(295);
        check("at_0259", 32'(bcd), 32'h0259);
        cyc(4);
        check("adj_wait", 32'(bcd), 32'h0259);
        cyc(1);
        check("adj_sec_wrap", 32'(bcd), 32'h0200);
        sel = 1'b0;
        cyc(25);
        check("adj_min_0700", 32'(bcd), 32'h0700);

        // reset mid-second at 12:34
        cyc(25);
        sel = 1'b1;
        cyc(170);
        adj = 1'b0;
        check("at_1234", 32'(bcd), 32'h1234);
        check("run_1234", 32'(running), 32'd1);
        cyc(4);
        check("mid_sec_1234", 32'(bcd), 32'h1234);
        rst = 1'b1;
        cyc(1);
        check("rst_digits", 32'(bcd), 32'h0000);
        check("rst_running", 32'(running), 32'd1);
        rst = 1'b0;
        cyc(9);
        check("post_rst_hold", 32'(bcd), 32'h0000);
        cyc(1);
        check("post_rst_0001", 32'(bcd), 32'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
